// File: rtl/pong_renderer.sv
// pong_renderer: erases the previously drawn paddles and ball, then draws them
// at their new positions, one pixel write per clock into a 160x120 adapter.
// Ports:
//   clock, resetn          system clock, asynchronous active-low reset
//   start                  frame request, sampled only while idle
//   lpad_y, rpad_y         top rows of left/right paddles
//   ball_x, ball_y         top-left corner of ball
//   x, y, colour, plot     registered pixel write to the adapter
//   busy                   high while a frame sequence runs
//   done                   one-cycle pulse when the sequence completes
module pong_renderer #(
  parameter int unsigned PADDLE_W  = 2,
  parameter int unsigned PADDLE_H  = 16,
  parameter int unsigned BALL_SIZE = 2,
  parameter int unsigned LEFT_X    = 4,
  parameter int unsigned RIGHT_X   = 154,
  parameter logic [2:0]  FG_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [6:0] lpad_y,
  input  logic [6:0] rpad_y,
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int unsigned COL_W = 4;
  localparam int unsigned ROW_W = 6;
  localparam int unsigned AX_W  = 9;
  localparam int unsigned AY_W  = 8;
  localparam int unsigned SCR_W = 160;
  localparam int unsigned SCR_H = 120;

  typedef enum logic [2:0] {
    IDLE, ERASE_L, ERASE_R, ERASE_B, DRAW_L, DRAW_R, DRAW_B, FINISH
  } state_t;

  state_t           state, state_n;
  logic [COL_W-1:0] col, col_n;
  logic [ROW_W-1:0] row, row_n;
  logic [6:0]       new_l, new_l_n, new_r, new_r_n, new_by, new_by_n;
  logic [7:0]       new_bx, new_bx_n;
  logic [6:0]       old_l, old_l_n, old_r, old_r_n, old_by, old_by_n;
  logic [7:0]       old_bx, old_bx_n;
  logic             drawn, drawn_n;
  logic [7:0]       x_n;
  logic [6:0]       y_n;
  logic [2:0]       colour_n;
  logic             plot_n, busy_n, done_n;

  // Current rectangle description and scan address
  logic [AX_W-1:0]  rect_x0, px;
  logic [AY_W-1:0]  rect_y0, py;
  logic [COL_W-1:0] rect_last_col;
  logic [ROW_W-1:0] rect_last_row;
  logic [2:0]       rect_colour;
  state_t           rect_next;

  // Next-state, datapath and output logic
  always_comb begin
    state_n  = state;
    col_n    = col;
    row_n    = row;
    new_l_n  = new_l;
    new_r_n  = new_r;
    new_bx_n = new_bx;
    new_by_n = new_by;
    old_l_n  = old_l;
    old_r_n  = old_r;
    old_bx_n = old_bx;
    old_by_n = old_by;
    drawn_n  = drawn;
    x_n      = x;
    y_n      = y;
    colour_n = colour;
    plot_n   = 1'b0;
    busy_n   = busy;
    done_n   = 1'b0;

    rect_x0       = '0;
    rect_y0       = '0;
    rect_last_col = COL_W'(PADDLE_W - 1);
    rect_last_row = ROW_W'(PADDLE_H - 1);
    rect_colour   = FG_COLOUR;
    rect_next     = IDLE;

    // Select rectangle source: erase uses last-drawn positions, draw uses latched ones
    case (state)
      ERASE_L: begin
        rect_x0 = AX_W'(LEFT_X);   rect_y0 = {1'b0, old_l};
        rect_colour = BG_COLOUR;   rect_next = ERASE_R;
      end
      ERASE_R: begin
        rect_x0 = AX_W'(RIGHT_X);  rect_y0 = {1'b0, old_r};
        rect_colour = BG_COLOUR;   rect_next = ERASE_B;
      end
      ERASE_B: begin
        rect_x0 = {1'b0, old_bx};  rect_y0 = {1'b0, old_by};
        rect_last_col = COL_W'(BALL_SIZE - 1);
        rect_last_row = ROW_W'(BALL_SIZE - 1);
        rect_colour = BG_COLOUR;   rect_next = DRAW_L;
      end
      DRAW_L: begin
        rect_x0 = AX_W'(LEFT_X);   rect_y0 = {1'b0, new_l};
        rect_next = DRAW_R;
      end
      DRAW_R: begin
        rect_x0 = AX_W'(RIGHT_X);  rect_y0 = {1'b0, new_r};
        rect_next = DRAW_B;
      end
      DRAW_B: begin
        rect_x0 = {1'b0, new_bx};  rect_y0 = {1'b0, new_by};
        rect_last_col = COL_W'(BALL_SIZE - 1);
        rect_last_row = ROW_W'(BALL_SIZE - 1);
        rect_next = FINISH;
      end
      default: ;
    endcase

    // Wide address sums so off-screen pixels never wrap back onto row/column 0
    px = rect_x0 + AX_W'(col);
    py = rect_y0 + AY_W'(row);

    case (state)
      IDLE: begin
        if (start) begin
          new_l_n  = lpad_y;
          new_r_n  = rpad_y;
          new_bx_n = ball_x;
          new_by_n = ball_y;
          col_n    = '0;
          row_n    = '0;
          busy_n   = 1'b1;
          state_n  = drawn ? ERASE_L : DRAW_L;
        end
      end
      FINISH: begin
        old_l_n  = new_l;
        old_r_n  = new_r;
        old_bx_n = new_bx;
        old_by_n = new_by;
        drawn_n  = 1'b1;
        done_n   = 1'b1;
        busy_n   = 1'b0;
        state_n  = IDLE;
      end
      default: begin
        x_n      = px[7:0];
        y_n      = py[6:0];
        colour_n = rect_colour;
        plot_n   = (px < AX_W'(SCR_W)) && (py < AY_W'(SCR_H));
        if (col == rect_last_col) begin
          col_n = '0;
          if (row == rect_last_row) begin
            row_n   = '0;
            state_n = rect_next;
          end else begin
            row_n = row + ROW_W'(1);
          end
        end else begin
          col_n = col + COL_W'(1);
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      col    <= '0;
      row    <= '0;
      new_l  <= '0;
      new_r  <= '0;
      new_bx <= '0;
      new_by <= '0;
      old_l  <= '0;
      old_r  <= '0;
      old_bx <= '0;
      old_by <= '0;
      drawn  <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      col    <= col_n;
      row    <= row_n;
      new_l  <= new_l_n;
      new_r  <= new_r_n;
      new_bx <= new_bx_n;
      new_by <= new_by_n;
      old_l  <= old_l_n;
      old_r  <= old_r_n;
      old_bx <= old_bx_n;
      old_by <= old_by_n;
      drawn  <= drawn_n;
      x      <= x_n;
      y      <= y_n;
      colour <= colour_n;
      plot   <= plot_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

endmodule

// File: doc/pong_renderer.md
# pong_renderer

Frame renderer for the Pong game. It sits between the game-state logic and the 160x120 VGA adapter. On each frame request it erases the previously drawn left paddle, right paddle and ball by repainting them in the background colour. It then draws all three at their new positions, emitting one pixel write per clock on the adapter's x/y/colour/plot inputs.

## Interface
- PADDLE_W, 2, paddle width in pixels (1..8)
- PADDLE_H, 16, paddle height in pixels (1..32)
- BALL_SIZE, 2, ball edge length in pixels (1..8)
- LEFT_X, 4, fixed x of left paddle's left column
- RIGHT_X, 154, fixed x of right paddle's left column
- FG_COLOUR, 3'b111, draw colour
- BG_COLOUR, 3'b000, erase colour

Ports:
- clock  in  1  system clock (CLOCK_50 at top level)
- resetn  in  1  asynchronous, active-low reset
- start  in  1  frame request; sampled only when idle
- lpad_y  in  7  top row of left paddle
- rpad_y  in  7  top row of right paddle
- ball_x  in  8  left column of ball
- ball_y  in  7  top row of ball
- x  out  8  pixel column to adapter
- y  out  7  pixel row to adapter
- colour  out  3  pixel colour to adapter
- plot  out  1  pixel write enable to adapter
- busy  out  1  high while a frame sequence is in progress
- done  out  1  one-cycle pulse at end of a frame sequence

## Operation
- States: IDLE, ERASE_L, ERASE_R, ERASE_B, DRAW_L, DRAW_R, DRAW_B, FINISH.
- IDLE with start=1: latch lpad_y, rpad_y, ball_x and ball_y into "new" registers. Go to ERASE_L if drawn=1, else DRAW_L.
- Erase states use the "old" registers (positions of the last drawn frame) and colour=BG_COLOUR. Draw states use the "new" registers and colour=FG_COLOUR.
- Each rectangle is scanned row-major, column fastest: (x0,y0), (x0+1,y0) … (x0+W-1,y0), (x0,y0+1) …
- One pixel per clock; there are no idle cycles between rectangles.
- Order: ERASE_L → ERASE_R → ERASE_B → DRAW_L → DRAW_R → DRAW_B → FINISH.
- FINISH:
  - copy new→old;
  - set drawn=1;
  - pulse done;
  - return to IDLE.
- Address arithmetic is 9 bits for x and 8 bits for y.
  - A pixel with x>159 or y>119 still consumes its cycle, with plot=0.
  - No wrap-around is allowed; clipped pixels must never alias onto row/column 0.
- start while busy=1 is ignored and not queued. Inputs may change freely while busy; only the latched copies are used.
- Reset (any time, including mid-frame):
  - x=0, y=0, colour=0, plot=0, busy=0, done=0;
  - drawn=0;
  - state=IDLE.
  - Pixels already written are not erased. The top level resets the adapter to the black background at the same time.

## Timing
- All outputs are registered.
- Let E0 be the edge that samples start=1 in IDLE. busy=1 from after E0.
- Pixel i (0-based) of the sequence is presented on x/y/colour/plot in the cycle after edge E0+1+i.
- Pixel count N:
  - with erase: N = 2·(2·PADDLE_W·PADDLE_H + BALL_SIZE²), which is 136 at defaults;
  - first frame after reset: N = 68 at defaults.
- After edge E0+N+1: plot=0, busy=0, done=1 for exactly one cycle.
- The earliest accepted next start is sampled at edge E0+N+2.
- plot is 0 whenever busy=0.

## Test plan
- Reset, then start with lpad_y=10, rpad_y=50, ball_x=80, ball_y=60:
  - exactly 68 plot pulses, all colour=111;
  - first pixel (4,10), pixel 32 at (154,50), last pixel (81,61);
  - done one cycle after the last pixel.
- Second start with lpad_y=12, rpad_y=50, ball_x=81, ball_y=60:
  - 136 cycles of plot;
  - first 68 have colour=000 and reproduce frame 1's coordinates;
  - last 68 have colour=111 at the new positions.
- Clipping, with ball_x=159, ball_y=119: ball pixels (160,119), (159,120) and (160,120) have plot=0 and (159,119) has plot=1. The cycle count is unchanged and no write occurs at x=0 or y=0.
- start held high continuously: frames are back-to-back with exactly one IDLE cycle between done and the next busy. start pulses during busy produce no extra frame.
- resetn asserted at pixel 40 of a frame: all outputs 0 asynchronously. The next start performs no erase (68 pixels).
- After reset, before any start: x, y, colour, plot, busy and done all stay 0 for 100 cycles.
